// File: rtl/jtdsp16_pkg.sv
// ============================================================================
// Module      : jtdsp16_pkg
// Description : Shared types and constants for the JTDSP16 do-loop sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtdsp16_pkg;

    localparam int c_kw_def     = 7;
    localparam int c_nw_def     = 4;
    localparam int c_data_n_lsb = 0;
    localparam int c_data_k_lsb = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } do_state_e;

endpackage

`default_nettype wire

// File: rtl/jtdsp16_do_cnt.sv
// ============================================================================
// Module      : jtdsp16_do_cnt
// Description : Nested body-offset / iteration counter pair with terminal decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtdsp16_do_cnt #(
    parameter int KW = 7,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [KW-1:0] k_load,
    input  logic [NW-1:0] nlen,
    output logic [NW-1:0] ncnt,
    output logic [KW-1:0] kcnt,
    output logic          last
);

    logic [NW-1:0] ncnt_d, ncnt_q;
    logic [KW-1:0] kcnt_d, kcnt_q;
    logic          w_wrap;

    assign w_wrap = (ncnt_q == nlen);
    assign last   = w_wrap & (kcnt_q == KW'(1));
    assign ncnt   = ncnt_q;
    assign kcnt   = kcnt_q;

    always_comb begin
        ncnt_d = ncnt_q;
        kcnt_d = kcnt_q;
        if (load) begin
            ncnt_d = NW'(1);
            kcnt_d = k_load;
        end else if (step) begin
            // Clearing on the final instruction keeps both counters at zero while idle
            if (last) begin
                ncnt_d = '0;
                kcnt_d = '0;
            end else if (w_wrap) begin
                ncnt_d = NW'(1);
                kcnt_d = kcnt_q - KW'(1);
            end else begin
                ncnt_d = ncnt_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ncnt_q <= '0;
            kcnt_q <= '0;
        end else begin
            ncnt_q <= ncnt_d;
            kcnt_q <= kcnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtdsp16_do_seq.sv
// ============================================================================
// Module      : jtdsp16_do_seq
// Description : Do/redo loop sequencer feeding the ROM address unit's loop cache,
//               with interrupt deferral. Define JTDSP16_DO_CLOOP_EN to let
//               k_field==0 take the iteration count from cloop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtdsp16_do_seq
    import jtdsp16_pkg::*;
#(
    parameter int KW = c_kw_def,
    parameter int NW = c_nw_def
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            do_inst,
    input  logic            redo_inst,
    input  logic [NW-1:0]   n_field,
    input  logic [KW-1:0]   k_field,
    input  logic [KW-1:0]   cloop,
    input  logic            irq_req,
    output logic            do_start,
    output logic            do_save,
    output logic            do_redo,
    output logic            do_short,
    output logic            do_out,
    output logic [NW-1:0]   do_pc,
    output logic [KW+NW-1:0] do_data,
    output logic            irq_start,
    output logic            irq_hold,
    output logic            do_err
);

    do_state_e     state_d, state_q;
    logic [NW-1:0] nlen_d, nlen_q;
    logic [KW-1:0] klen_d, klen_q;
    logic          body_ok_d, body_ok_q;
    logic          irq_pend_d, irq_pend_q;
    logic          do_err_d, do_err_q;

    logic [KW-1:0] w_keff;
    logic [NW-1:0] w_ncnt;
    logic [KW-1:0] w_kcnt;
    logic          w_last;
    logic          w_idle;
    logic          w_run;
    logic          w_gate;
    logic          w_do_acc;
    logic          w_redo_acc;

`ifdef JTDSP16_DO_CLOOP_EN
    assign w_keff = (k_field == '0) ? cloop : k_field;
`else
    logic w_unused_cloop;
    assign w_keff         = k_field;
    assign w_unused_cloop = ^cloop;
`endif

    assign w_idle = (state_q == ST_IDLE);
    assign w_run  = (state_q == ST_RUN);

    // A pending interrupt owns the first idle slot, so no loop may start then
    assign w_gate     = cen & w_idle & ~irq_pend_q;
    assign w_do_acc   = w_gate & do_inst & (n_field != '0) & (w_keff != '0);
    assign w_redo_acc = w_gate & ~do_inst & redo_inst & body_ok_q & (w_keff != '0);

    jtdsp16_do_cnt #(
        .KW (KW),
        .NW (NW)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (do_start),
        .step   (cen & w_run),
        .k_load (w_keff),
        .nlen   (nlen_q),
        .ncnt   (w_ncnt),
        .kcnt   (w_kcnt),
        .last   (w_last)
    );

    always_comb begin
        state_d    = state_q;
        nlen_d     = nlen_q;
        klen_d     = klen_q;
        body_ok_d  = body_ok_q;
        irq_pend_d = irq_pend_q;
        do_err_d   = do_err_q;
        do_start   = w_do_acc | w_redo_acc;
        do_save    = w_do_acc;
        do_redo    = w_redo_acc;
        irq_start  = cen & w_idle & (irq_pend_q | (irq_req & ~(w_do_acc | w_redo_acc)));

        case (state_q)
            ST_IDLE: if (w_do_acc | w_redo_acc) state_d = ST_RUN;
            ST_RUN:  if (cen & w_last)          state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase

        if (w_do_acc) begin
            nlen_d    = n_field;
            body_ok_d = 1'b1;
        end
        if (w_do_acc | w_redo_acc) begin
            klen_d = w_keff;
        end

        if (cen) begin
            if ((do_inst | redo_inst) & ~(w_do_acc | w_redo_acc)) do_err_d = 1'b1;
            if (do_inst & redo_inst)                                do_err_d = 1'b1;
            if (w_idle & irq_pend_q) begin
                irq_pend_d = 1'b0;
            end else if (irq_req & (w_run | w_do_acc | w_redo_acc)) begin
                irq_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            nlen_q     <= '0;
            klen_q     <= '0;
            body_ok_q  <= 1'b0;
            irq_pend_q <= 1'b0;
            do_err_q   <= 1'b0;
        end else if (cen) begin
            state_q    <= state_d;
            nlen_q     <= nlen_d;
            klen_q     <= klen_d;
            body_ok_q  <= body_ok_d;
            irq_pend_q <= irq_pend_d;
            do_err_q   <= do_err_d;
        end
    end

    // A redo reuses the latched body, so its length comes from nlen
    assign do_short = w_do_acc ? (n_field == NW'(1)) : (nlen_q == NW'(1));
    assign do_out   = w_run & w_last;
    assign do_pc    = w_run ? w_ncnt : '0;
    assign irq_hold = irq_pend_q;
    assign do_err   = do_err_q;

    assign do_data[c_data_n_lsb +: NW] = nlen_q;
    assign do_data[c_data_k_lsb +: KW] = klen_q;

endmodule

`default_nettype wire

// File: tb/tb_jtdsp16_do_seq.sv
// ============================================================================
// Module      : tb_jtdsp16_do_seq
// Description : Self-checking bench for jtdsp16_do_seq (vector table, directed
//               corner sequences, randomized traffic against a loop-position model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtdsp16_do_seq;

    logic        clk = 1'b0;
    logic        rst_n, cen, do_inst, redo_inst, irq_req;
    logic [3:0]  n_field;
    logic [6:0]  k_field, cloop;
    logic        do_start, do_save, do_redo, do_short, do_out;
    logic [3:0]  do_pc;
    logic [10:0] do_data;
    logic        irq_start, irq_hold, do_err;

    jtdsp16_do_seq #(.KW(7), .NW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .do_inst   (do_inst),
        .redo_inst (redo_inst),
        .n_field   (n_field),
        .k_field   (k_field),
        .cloop     (cloop),
        .irq_req   (irq_req),
        .do_start  (do_start),
        .do_save   (do_save),
        .do_redo   (do_redo),
        .do_short  (do_short),
        .do_out    (do_out),
        .do_pc     (do_pc),
        .do_data   (do_data),
        .irq_start (irq_start),
        .irq_hold  (irq_hold),
        .do_err    (do_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Loop model: a running loop is just a position within N*K body slots
    bit m_active, m_body_ok, m_pend, m_err;
    int m_elapsed, m_n, m_kl;

    bit s_rn, s_cen, s_di, s_ri, s_irq, s_start, s_save, s_out;
    int s_n, s_keff;

    typedef struct {
        bit cen, di, ri;
        int n, k;
        bit irq;
        bit start, save, rdo, sh, out;
        int pc;
        bit irqs, hold, err;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit rn, input bit c, input bit di, input bit ri,
                         input int n, input int k, input bit irq, input int cl);
        int keff;
        bit idle, e_do, e_ri, e_start, e_irqs, e_out;
        int e_pc;
        rst_n = rn; cen = c; do_inst = di; redo_inst = ri;
        n_field = n[3:0]; k_field = k[6:0]; cloop = cl[6:0]; irq_req = irq;
        #1;
        keff = k;
`ifdef JTDSP16_DO_CLOOP_EN
        if (k == 0) keff = cl;
`endif
        idle    = !m_active;
        e_do    = c && idle && !m_pend && di && (n != 0) && (keff != 0);
        e_ri    = c && idle && !m_pend && !di && ri && m_body_ok && (keff != 0);
        e_start = e_do || e_ri;
        e_irqs  = c && idle && (m_pend || (irq && !e_start));
        e_out   = m_active && (m_elapsed == m_n * m_kl - 1);
        e_pc    = m_active ? (m_elapsed % m_n) + 1 : 0;
        chk("do_start",  do_start,  e_start);
        chk("do_save",   do_save,   e_do);
        chk("do_redo",   do_redo,   e_ri);
        chk("do_short",  do_short,  e_do ? (n == 1) : (m_n == 1));
        chk("do_out",    do_out,    e_out);
        chk("do_pc",     do_pc,     e_pc);
        chk("do_data",   do_data,   m_kl * 16 + m_n);
        chk("irq_start", irq_start, e_irqs);
        chk("irq_hold",  irq_hold,  m_pend);
        chk("do_err",    do_err,    m_err);
        s_rn = rn; s_cen = c; s_di = di; s_ri = ri; s_irq = irq;
        s_n = n; s_keff = keff; s_start = e_start; s_save = e_do; s_out = e_out;
    endtask

    task automatic tick();
        if (!s_rn) begin
            m_active = 0; m_body_ok = 0; m_pend = 0; m_err = 0;
            m_elapsed = 0; m_n = 0; m_kl = 0;
        end else if (s_cen) begin
            if ((s_di || s_ri) && !s_start) m_err = 1;
            if (s_di && s_ri)               m_err = 1;
            if (!m_active && m_pend)                  m_pend = 0;
            else if (s_irq && (m_active || s_start))  m_pend = 1;
            if (s_start) begin
                m_active = 1; m_elapsed = 0; m_kl = s_keff;
                if (s_save) begin m_n = s_n; m_body_ok = 1; end
            end else if (m_active) begin
                if (s_out) m_active = 0;
                else       m_elapsed++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step(input bit rn, input bit c, input bit di, input bit ri,
                        input int n, input int k, input bit irq, input int cl);
        drive(rn, c, di, ri, n, k, irq, cl);
        tick();
    endtask

    task automatic do_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic count_run(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            if (do_pc == 0) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int pcs[$];
        tbl[0]  = '{1,1,0,3,2,0, 1,1,0,0,0,0, 0,0,0};
        tbl[1]  = '{1,0,0,0,0,0, 0,0,0,0,0,1, 0,0,0};
        tbl[2]  = '{1,0,0,0,0,0, 0,0,0,0,0,2, 0,0,0};
        tbl[3]  = '{1,0,0,0,0,0, 0,0,0,0,0,3, 0,0,0};
        tbl[4]  = '{1,0,0,0,0,0, 0,0,0,0,0,1, 0,0,0};
        tbl[5]  = '{1,0,0,0,0,0, 0,0,0,0,0,2, 0,0,0};
        tbl[6]  = '{1,0,0,0,0,0, 0,0,0,0,1,3, 0,0,0};
        tbl[7]  = '{1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0};
        tbl[8]  = '{1,1,0,1,1,0, 1,1,0,1,0,0, 0,0,0};
        tbl[9]  = '{1,0,0,0,0,0, 0,0,0,1,1,1, 0,0,0};
        tbl[10] = '{1,0,0,0,0,0, 0,0,0,1,0,0, 0,0,0};
        tbl[11] = '{1,0,0,0,0,1, 0,0,0,1,0,0, 1,0,0};
        tbl[12] = '{1,1,0,0,3,0, 0,0,0,1,0,0, 0,0,0};
        tbl[13] = '{1,0,0,0,0,0, 0,0,0,1,0,0, 0,0,1};
        tbl[14] = '{0,1,0,2,2,0, 0,0,0,1,0,0, 0,0,1};
        tbl[15] = '{1,0,1,1,2,0, 1,0,1,1,0,0, 0,0,1};
        tbl[16] = '{1,0,0,0,0,0, 0,0,0,1,0,1, 0,0,1};
        tbl[17] = '{1,0,0,0,0,0, 0,0,0,1,1,1, 0,0,1};

        rst_n = 0; cen = 0; do_inst = 0; redo_inst = 0; irq_req = 0;
        n_field = 0; k_field = 0; cloop = 0;
        m_active = 0; m_body_ok = 0; m_pend = 0; m_err = 0;
        m_elapsed = 0; m_n = 0; m_kl = 0;
        @(negedge clk);
        do_reset();

        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_do_pc",   do_pc,    0);
        chk("rst_do_data", do_data,  0);
        chk("rst_do_err",  do_err,   0);
        chk("rst_hold",    irq_hold, 0);
        chk("rst_short",   do_short, 0);

        for (int i = 0; i < 18; i++) begin
            drive(1, tbl[i].cen, tbl[i].di, tbl[i].ri, tbl[i].n, tbl[i].k, tbl[i].irq, 0);
            chk($sformatf("tbl%0d_start", i), do_start,  tbl[i].start);
            chk($sformatf("tbl%0d_save",  i), do_save,   tbl[i].save);
            chk($sformatf("tbl%0d_redo",  i), do_redo,   tbl[i].rdo);
            chk($sformatf("tbl%0d_short", i), do_short,  tbl[i].sh);
            chk($sformatf("tbl%0d_out",   i), do_out,    tbl[i].out);
            chk($sformatf("tbl%0d_pc",    i), do_pc,     tbl[i].pc);
            chk($sformatf("tbl%0d_irqs",  i), irq_start, tbl[i].irqs);
            chk($sformatf("tbl%0d_hold",  i), irq_hold,  tbl[i].hold);
            chk($sformatf("tbl%0d_err",   i), do_err,    tbl[i].err);
            tick();
        end

        // redo K=4 over a previously captured N=2 body
        do_reset();
        step(1, 1, 1, 0, 2, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 2, 4, 0, 0);
        chk("redo_strobe", do_redo,  1);
        chk("redo_save",   do_save,  0);
        chk("redo_short",  do_short, 0);
        tick();
        count_run(cnt);
        chk("redo_len", cnt, 8);

        // interrupt raised mid-loop is held until the loop ends
        do_reset();
        step(1, 1, 1, 0, 2, 3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0, 0, (i == 1), 0);
            chk("irq_mid_start", irq_start, 0);
            if (i >= 2) chk("irq_mid_hold", irq_hold, 1);
            if (i == 5) chk("irq_mid_out", do_out, 1);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("irq_fire", irq_start, 1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("irq_clear", irq_hold, 0);
        tick();

        // nested do inside a running loop
        do_reset();
        step(1, 1, 1, 0, 2, 2, 0, 0);
        drive(1, 1, 1, 0, 3, 3, 0, 0);
        chk("nest_start", do_start, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("nest_err", do_err, 1);
        tick();
        count_run(cnt);

        // redo with no captured body
        do_reset();
        drive(1, 1, 0, 1, 0, 3, 0, 0);
        chk("redo_rst_start", do_start, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        chk("redo_rst_err", do_err, 1);
        chk("redo_rst_pc",  do_pc,  0);
        tick();

        // cen toggling: offsets advance only on enabled cycles
        do_reset();
        step(1, 1, 1, 0, 3, 2, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, (i % 2 == 0), 0, 0, 0, 0, 0, 0);
            if ((i % 2 == 0) && do_pc != 0) pcs.push_back(int'(do_pc));
            tick();
        end
        chk("cen_count", pcs.size(), 6);
        for (int j = 0; j < pcs.size() && j < 6; j++)
            chk("cen_pc", pcs[j], (j % 3) + 1);

        // k_field==0 with cloop=5
        do_reset();
        step(1, 1, 1, 0, 2, 0, 0, 5);
        count_run(cnt);
`ifdef JTDSP16_DO_CLOOP_EN
        chk("cloop_len", cnt, 10);
`else
        chk("cloop_len", cnt, 0);
        chk("cloop_err", do_err, 1);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rn, c, di, ri, irq;
            int n, k, cl;
            rn  = ($urandom_range(0, 199) != 0);
            c   = ($urandom_range(0, 3) != 0);
            di  = ($urandom_range(0, 9) == 0);
            ri  = ($urandom_range(0, 14) == 0);
            irq = ($urandom_range(0, 19) == 0);
            n   = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5);
            k   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            cl  = $urandom_range(0, 6);
            if (ri && !di) n = m_n;
            step(rn, c, di, ri, n, k, irq, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
